icache_ctrl: RTL and testbench
==============================

ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-002 SHALL have parameter SETS, default 256: set count, power of two and at least 2.
REQ-003 SHALL have parameter WAYS, default 4: associativity, power of two, 2..8.
REQ-004 SHALL have parameter LINE_BYTES, default 64: line size; offset width OFF_W = log2(LINE_BYTES), index width IDX_W = log2(SETS), tag = remaining upper bits.
REQ-005 SHALL have parameter CNT_W, default 32: statistics counter width.
REQ-006 SHALL have port clk, in, 1: clock; all state changes on the rising edge.
REQ-007 SHALL have port rst, in, 1: synchronous, active-high reset.
REQ-008 SHALL have ports req_valid in 1, req_ready out 1, req_cmd in 2, req_addr in ADDR_W: command request; commands are READ=0, INVAL=1, CLEAR=2, NOP=3.
REQ-009 SHALL have ports rsp_valid out 1 and rsp_hit out 1: one-cycle completion pulse and its hit flag.
REQ-010 SHALL have ports l2_req_valid out 1, l2_req_ready in 1, l2_req_addr out ADDR_W, l2_rsp_valid in 1: line-fill handshake.
REQ-011 SHALL have ports stat_reads, stat_hits, stat_misses, stat_invals, each out CNT_W: statistics counters.
REQ-012 SHALL have ports dbg_set in IDX_W, dbg_way in log2(WAYS), dbg_entry out: registered entry readback, one-cycle latency, valid in any state.

Function
REQ-013 Each entry SHALL hold tag, valid bit and a log2(WAYS)-bit age (0 = MRU, WAYS-1 = LRU); ages within a set SHALL always form a permutation.
REQ-014 The FSM SHALL have states INIT, IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL.
REQ-015 INIT SHALL write one set per cycle (valid=0, tag=0, way w age=WAYS-1-w), taking SETS cycles, then go to IDLE; req_ready=0 throughout.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready, and the command and address SHALL be registered.
REQ-017 LOOKUP SHALL occur one cycle after accept; a match SHALL require valid && tag equality; multiple matches are impossible by construction.
REQ-018 READ hit: rsp_valid=1 and rsp_hit=1 in the LOOKUP cycle (accept + 1); the hit way's age becomes 0, younger ways increment; return to IDLE.
REQ-019 READ miss: enter MISS_REQ; assert l2_req_valid with a line-aligned l2_req_addr, held until l2_req_ready; then enter MISS_WAIT.
REQ-020 MISS_WAIT SHALL wait indefinitely for l2_rsp_valid, then enter FILL.
REQ-021 The FILL victim SHALL be the lowest-numbered invalid way if any exists, else the way with age WAYS-1.
REQ-022 FILL SHALL write tag, set valid, apply the MRU update of REQ-018, and pulse rsp_valid=1 with rsp_hit=0.
REQ-023 INVAL hit: clear valid, set the way's age to WAYS-1, decrement ways older than its old age, rsp_hit=1; INVAL miss: no array change, rsp_hit=0; both complete in LOOKUP.
REQ-024 CLEAR SHALL re-enter INIT; on INIT exit it SHALL pulse rsp_valid with rsp_hit=0; statistics SHALL be preserved.
REQ-025 NOP SHALL complete in LOOKUP with rsp_hit=0 and no state change.
REQ-026 l2_rsp_valid outside MISS_WAIT SHALL be ignored.
REQ-027 Counters SHALL wrap modulo 2^CNT_W; stat_reads increments per READ, stat_hits per READ hit, stat_misses per READ miss, stat_invals per INVAL hit.

Reset
REQ-028 On rst, outputs SHALL go to req_ready=0, rsp_valid=0, rsp_hit=0, l2_req_valid=0, l2_req_addr=0, counters 0, dbg_entry=0; the state SHALL go to INIT.
REQ-029 rst in any state, including mid-miss, SHALL abort the operation with no rsp_valid and drop l2_req_valid on the next edge; the pending L2 response is then ignored.

Configuration
REQ-030 With ICACHE_STATS_EN defined, counters SHALL operate per REQ-027; undefined, all stat_* outputs SHALL be constant 0 and no counter flops SHALL be inferred.

Structure
REQ-031 Package icache_pkg SHALL hold the command encodings, the FSM state enum and the entry struct typedef.
REQ-032 Sub-module icache_lru SHALL compute the victim way and the next ages for one set; all other logic stays in icache_ctrl.

Verification
REQ-033 After reset, wait SETS cycles, then dbg read set 0 way 3 -> valid=0, age=0; req_ready rises exactly SETS cycles after rst falls.
REQ-034 READ 0x0000_1000 -> l2_req_addr=0x0000_1000; l2_rsp_valid after 5 cycles -> rsp_hit=0; READ same address again -> rsp_hit=1 at accept+1; stat_hits=1, stat_misses=1.
REQ-035 Five READs with distinct tags to set 0 (WAYS=4) -> the fifth evicts the first tag; re-reading the first tag misses.
REQ-036 INVAL of a resident line -> rsp_hit=1, entry valid=0, age=3; next READ refills that way.
REQ-037 rst asserted in MISS_WAIT, then l2_rsp_valid -> no rsp_valid and no fill; the FSM is in INIT.
REQ-038 Build without ICACHE_STATS_EN, 10 READs -> all stat_* remain 0.

Source files
------------

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - command encodings, FSM states and entry layout for the icache controller
package icache_pkg;

    typedef enum logic [1:0] {
        CMD_READ  = 2'd0,
        CMD_INVAL = 2'd1,
        CMD_CLEAR = 2'd2,
        CMD_NOP   = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOOKUP,
        ST_MISS_REQ,
        ST_MISS_WAIT,
        ST_FILL
    } state_e;

    // Debug view of one entry; tag and age are zero-extended to fixed widths.
    typedef struct packed {
        logic [63:0] tag;
        logic        valid;
        logic [2:0]  age;
    } entry_t;

endpackage

// File: rtl/icache_lru.sv
// rtl/icache_lru.sv - victim selection and age-update helper for one cache set
module icache_lru #(
    parameter int WAYS  = 4,
    parameter int AGE_W = $clog2(WAYS)
) (
    input  logic [WAYS*AGE_W-1:0] ages,
    input  logic [WAYS-1:0]       valid,
    input  logic [AGE_W-1:0]      sel_way,
    output logic [AGE_W-1:0]      victim,
    output logic [WAYS*AGE_W-1:0] ages_mru,
    output logic [WAYS*AGE_W-1:0] ages_lru
);

    logic [AGE_W-1:0] sel_age;
    logic [AGE_W-1:0] age_w;

    always_comb begin
        sel_age  = ages[sel_way*AGE_W +: AGE_W];
        victim   = '0;
        ages_mru = ages;
        ages_lru = ages;
        age_w    = '0;
        for (int w = 0; w < WAYS; w++) begin
            age_w = ages[w*AGE_W +: AGE_W];
            if (AGE_W'(w) == sel_way) begin
                ages_mru[w*AGE_W +: AGE_W] = '0;
                ages_lru[w*AGE_W +: AGE_W] = AGE_W'(WAYS-1);
            end else begin
                if (age_w < sel_age)
                    ages_mru[w*AGE_W +: AGE_W] = age_w + AGE_W'(1);
                if (age_w > sel_age)
                    ages_lru[w*AGE_W +: AGE_W] = age_w - AGE_W'(1);
            end
            if (age_w == AGE_W'(WAYS-1))
                victim = AGE_W'(w);
        end
        // Invalid ways take priority; scanning downward leaves the lowest one.
        for (int w = WAYS-1; w >= 0; w--) begin
            if (!valid[w])
                victim = AGE_W'(w);
        end
    end

endmodule

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - set-associative icache tag controller; ICACHE_STATS_EN enables statistics counters
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int SETS       = 256,
    parameter int WAYS       = 4,
    parameter int LINE_BYTES = 64,
    parameter int CNT_W      = 32,
    localparam int IDX_W     = $clog2(SETS),
    localparam int WAY_W     = $clog2(WAYS),
    localparam int OFF_W     = $clog2(LINE_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_cmd,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic              l2_req_valid,
    input  logic              l2_req_ready,
    output logic [ADDR_W-1:0] l2_req_addr,
    input  logic              l2_rsp_valid,
    output logic [CNT_W-1:0]  stat_reads,
    output logic [CNT_W-1:0]  stat_hits,
    output logic [CNT_W-1:0]  stat_misses,
    output logic [CNT_W-1:0]  stat_invals,
    input  logic [IDX_W-1:0]  dbg_set,
    input  logic [WAY_W-1:0]  dbg_way,
    output entry_t            dbg_entry
);

    localparam int LINE_W = ADDR_W - OFF_W;
    localparam int TAG_W  = LINE_W - IDX_W;

    state_e state, state_nxt;
    logic [IDX_W-1:0]  init_cnt;
    logic              clear_pend;
    logic [1:0]        cmd_r;
    logic [LINE_W-1:0] line_r;

    logic [WAYS*TAG_W-1:0] tag_mem [SETS];
    logic [WAYS-1:0]       val_mem [SETS];
    logic [WAYS*WAY_W-1:0] age_mem [SETS];

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag_q;
    logic [WAYS*TAG_W-1:0] set_tags;
    logic [WAYS-1:0]       set_val;
    logic [WAYS*WAY_W-1:0] set_age;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way, sel_way, victim;
    logic [WAYS*WAY_W-1:0] ages_mru, ages_lru, init_ages;
    logic                  init_last, in_lookup;
    entry_t                dbg_nxt;

    logic unused_off;
    assign unused_off = ^req_addr[OFF_W-1:0];

    assign idx       = line_r[IDX_W-1:0];
    assign tag_q     = line_r[LINE_W-1:IDX_W];
    assign set_tags  = tag_mem[idx];
    assign set_val   = val_mem[idx];
    assign set_age   = age_mem[idx];
    assign init_last = (init_cnt == IDX_W'(SETS-1));
    assign in_lookup = (state == ST_LOOKUP);
    assign sel_way   = (state == ST_FILL) ? victim : hit_way;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        init_ages = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (set_val[w] && set_tags[w*TAG_W +: TAG_W] == tag_q) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            init_ages[w*WAY_W +: WAY_W] = WAY_W'(WAYS-1-w);
        end
    end

    icache_lru #(.WAYS(WAYS), .AGE_W(WAY_W)) u_lru (
        .ages     (set_age),
        .valid    (set_val),
        .sel_way  (sel_way),
        .victim   (victim),
        .ages_mru (ages_mru),
        .ages_lru (ages_lru)
    );

    always_comb begin
        state_nxt    = state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_hit      = 1'b0;
        l2_req_valid = 1'b0;
        case (state)
            ST_INIT: begin
                if (init_last) begin
                    state_nxt = ST_IDLE;
                    rsp_valid = clear_pend;
                end
            end
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nxt = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                case (cmd_r)
                    CMD_READ: begin
                        if (hit) begin
                            rsp_valid = 1'b1;
                            rsp_hit   = 1'b1;
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_MISS_REQ;
                        end
                    end
                    CMD_INVAL: begin
                        rsp_valid = 1'b1;
                        rsp_hit   = hit;
                        state_nxt = ST_IDLE;
                    end
                    CMD_CLEAR: state_nxt = ST_INIT;
                    default: begin
                        rsp_valid = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                endcase
            end
            ST_MISS_REQ: begin
                l2_req_valid = 1'b1;
                if (l2_req_ready)
                    state_nxt = ST_MISS_WAIT;
            end
            ST_MISS_WAIT: begin
                if (l2_rsp_valid)
                    state_nxt = ST_FILL;
            end
            ST_FILL: begin
                rsp_valid = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    assign l2_req_addr = l2_req_valid ? {line_r, {OFF_W{1'b0}}} : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_INIT;
            init_cnt   <= '0;
            clear_pend <= 1'b0;
            cmd_r      <= '0;
            line_r     <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + IDX_W'(1);
                if (init_last)
                    clear_pend <= 1'b0;
            end
            if (in_lookup && cmd_r == CMD_CLEAR) begin
                clear_pend <= 1'b1;
                init_cnt   <= '0;
            end
            if (req_valid && req_ready) begin
                cmd_r  <= req_cmd;
                line_r <= req_addr[ADDR_W-1:OFF_W];
            end
        end
    end

    // Tag arrays carry no reset; INIT sweeps them after every reset or CLEAR.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                tag_mem[init_cnt] <= '0;
                val_mem[init_cnt] <= '0;
                age_mem[init_cnt] <= init_ages;
            end else if (in_lookup && hit && cmd_r == CMD_READ) begin
                age_mem[idx] <= ages_mru;
            end else if (in_lookup && hit && cmd_r == CMD_INVAL) begin
                val_mem[idx][hit_way] <= 1'b0;
                age_mem[idx]          <= ages_lru;
            end else if (state == ST_FILL) begin
                tag_mem[idx][victim*TAG_W +: TAG_W] <= tag_q;
                val_mem[idx][victim]                <= 1'b1;
                age_mem[idx]                        <= ages_mru;
            end
        end
    end

    always_comb begin
        dbg_nxt       = '0;
        dbg_nxt.tag   = 64'(tag_mem[dbg_set][dbg_way*TAG_W +: TAG_W]);
        dbg_nxt.valid = val_mem[dbg_set][dbg_way];
        dbg_nxt.age   = 3'(age_mem[dbg_set][dbg_way*WAY_W +: WAY_W]);
    end

    always_ff @(posedge clk) begin
        if (rst)
            dbg_entry <= '0;
        else
            dbg_entry <= dbg_nxt;
    end

`ifdef ICACHE_STATS_EN
    logic [CNT_W-1:0] cnt_reads, cnt_hits, cnt_misses, cnt_invals;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reads  <= '0;
            cnt_hits   <= '0;
            cnt_misses <= '0;
            cnt_invals <= '0;
        end else if (in_lookup) begin
            if (cmd_r == CMD_READ) begin
                cnt_reads <= cnt_reads + CNT_W'(1);
                if (hit)
                    cnt_hits <= cnt_hits + CNT_W'(1);
                else
                    cnt_misses <= cnt_misses + CNT_W'(1);
            end
            if (cmd_r == CMD_INVAL && hit)
                cnt_invals <= cnt_invals + CNT_W'(1);
        end
    end

    assign stat_reads  = cnt_reads;
    assign stat_hits   = cnt_hits;
    assign stat_misses = cnt_misses;
    assign stat_invals = cnt_invals;
`else
    assign stat_reads  = '0;
    assign stat_hits   = '0;
    assign stat_misses = '0;
    assign stat_invals = '0;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - randomized self-checking bench for icache_ctrl with a recency-list model
module tb_icache_ctrl;

    localparam int ADDR_W = 32, SETS = 256, WAYS = 4, LINE_BYTES = 64, CNT_W = 32;
    localparam int OFF_W = 6, IDX_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_cmd = 2'd3;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              rsp_valid, rsp_hit;
    logic              l2_req_valid;
    logic              l2_req_ready = 1'b0;
    logic [ADDR_W-1:0] l2_req_addr;
    logic              l2_rsp_valid = 1'b0;
    logic [CNT_W-1:0]  stat_reads, stat_hits, stat_misses, stat_invals;
    logic [IDX_W-1:0]  dbg_set = '0;
    logic [1:0]        dbg_way = '0;
    logic [67:0]       dbg_entry;

    icache_ctrl #(.ADDR_W(ADDR_W), .SETS(SETS), .WAYS(WAYS), .LINE_BYTES(LINE_BYTES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
        .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_addr(l2_req_addr),
        .l2_rsp_valid(l2_rsp_valid),
        .stat_reads(stat_reads), .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_invals(stat_invals),
        .dbg_set(dbg_set), .dbg_way(dbg_way), .dbg_entry(dbg_entry)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: per set a recency list of way numbers, position 0 = most recently used.
    int m_tag   [SETS][WAYS];
    bit m_val   [SETS][WAYS];
    int m_order [SETS][WAYS];
    int m_reads, m_hits, m_misses, m_invals;
    logic [ADDR_W-1:0] last_l2_addr;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_init_arrays();
        for (int s = 0; s < SETS; s++)
            for (int p = 0; p < WAYS; p++) begin
                m_tag[s][p]   = 0;
                m_val[s][p]   = 0;
                m_order[s][p] = WAYS - 1 - p;
            end
    endtask

    function automatic int age_of(input int s, input int w);
        for (int p = 0; p < WAYS; p++)
            if (m_order[s][p] == w) return p;
        return -1;
    endfunction

    function automatic int m_lookup(input int s, input int t);
        for (int w = 0; w < WAYS; w++)
            if (m_val[s][w] && m_tag[s][w] == t) return w;
        return -1;
    endfunction

    function automatic int m_victim(input int s);
        for (int w = 0; w < WAYS; w++)
            if (!m_val[s][w]) return w;
        return m_order[s][WAYS-1];
    endfunction

    task automatic m_touch(input int s, input int w);
        int p;
        p = age_of(s, w);
        for (int q = p; q > 0; q--) m_order[s][q] = m_order[s][q-1];
        m_order[s][0] = w;
    endtask

    task automatic m_demote(input int s, input int w);
        int p;
        p = age_of(s, w);
        for (int q = p; q < WAYS-1; q++) m_order[s][q] = m_order[s][q+1];
        m_order[s][WAYS-1] = w;
    endtask

    function automatic logic [67:0] m_entry(input int s, input int w);
        return {64'(m_tag[s][w]), m_val[s][w], 3'(age_of(s, w))};
    endfunction

    function automatic logic [CNT_W-1:0] exp_stat(input int v);
`ifdef ICACHE_STATS_EN
        return CNT_W'(v);
`else
        return '0;
`endif
    endfunction

    task automatic chk_stats();
        chk("stat_reads",  stat_reads,  exp_stat(m_reads));
        chk("stat_hits",   stat_hits,   exp_stat(m_hits));
        chk("stat_misses", stat_misses, exp_stat(m_misses));
        chk("stat_invals", stat_invals, exp_stat(m_invals));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic dbg_read(input int s, input int w, output logic [67:0] e);
        @(negedge clk);
        dbg_set = IDX_W'(s);
        dbg_way = 2'(w);
        @(negedge clk);
        e = dbg_entry;
    endtask

    task automatic dbg_chk(input int s, input int w);
        logic [67:0] e;
        dbg_read(s, w, e);
        chk($sformatf("dbg_s%0d_w%0d", s, w), e, m_entry(s, w));
    endtask

    function automatic logic [ADDR_W-1:0] mk_addr(input int t, input int s, input int off);
        return ADDR_W'((t << (OFF_W + IDX_W)) | (s << OFF_W) | off);
    endfunction

    task automatic do_cmd(input logic [1:0] cmd, input logic [ADDR_W-1:0] addr,
                          input int l2_wait, input int rdy_wait, output bit got_hit);
        int s, t, mw, v;
        got_hit = 0;
        wait_ready();
        chk_stats();
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        s  = int'(addr[OFF_W +: IDX_W]);
        t  = int'(addr[ADDR_W-1:OFF_W+IDX_W]);
        mw = m_lookup(s, t);
        case (cmd)
            2'd0: begin
                m_reads++;
                if (mw >= 0) begin
                    chk("rd_hit_valid", rsp_valid, 1);
                    chk("rd_hit_flag", rsp_hit, 1);
                    got_hit = rsp_hit;
                    m_hits++;
                    m_touch(s, mw);
                end else begin
                    chk("rd_miss_novalid", rsp_valid, 0);
                    m_misses++;
                    @(negedge clk);
                    chk("l2_req_valid", l2_req_valid, 1);
                    chk("l2_req_addr", l2_req_addr, addr & ~ADDR_W'(LINE_BYTES-1));
                    last_l2_addr = l2_req_addr;
                    for (int i = 0; i < rdy_wait; i++) begin
                        l2_rsp_valid = 1'($urandom);
                        @(negedge clk);
                        chk("l2_req_hold", l2_req_valid, 1);
                        chk("rsp_in_missreq", rsp_valid, 0);
                    end
                    l2_rsp_valid = 1'b0;
                    l2_req_ready = 1'b1;
                    @(negedge clk);
                    l2_req_ready = 1'b0;
                    chk("l2_req_drop", l2_req_valid, 0);
                    for (int i = 0; i < l2_wait; i++) begin
                        chk("rsp_in_wait", rsp_valid, 0);
                        @(negedge clk);
                    end
                    l2_rsp_valid = 1'b1;
                    @(negedge clk);
                    l2_rsp_valid = 1'b0;
                    chk("fill_valid", rsp_valid, 1);
                    chk("fill_hit", rsp_hit, 0);
                    got_hit = rsp_hit;
                    v = m_victim(s);
                    m_tag[s][v] = t;
                    m_val[s][v] = 1;
                    m_touch(s, v);
                end
            end
            2'd1: begin
                chk("inv_valid", rsp_valid, 1);
                chk("inv_hit", rsp_hit, (mw >= 0));
                got_hit = rsp_hit;
                if (mw >= 0) begin
                    m_invals++;
                    m_val[s][mw] = 0;
                    m_demote(s, mw);
                end
            end
            2'd2: begin
                chk("clr_novalid", rsp_valid, 0);
                for (int k = 1; k <= SETS; k++) begin
                    @(negedge clk);
                    chk("clr_init_rsp", rsp_valid, (k == SETS));
                    chk("clr_init_ready", req_ready, 0);
                end
                @(negedge clk);
                chk("clr_ready", req_ready, 1);
                m_init_arrays();
            end
            default: begin
                chk("nop_valid", rsp_valid, 1);
                chk("nop_hit", rsp_hit, 0);
            end
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            l2_rsp_valid = 1'($urandom);
            @(negedge clk);
            chk("idle_rsp", rsp_valid, 0);
            chk("idle_ready", req_ready, 1);
        end
        l2_rsp_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h;
        logic [67:0] e;
        logic [ADDR_W-1:0] a;
        int cmd_sel;
        m_reads = 0; m_hits = 0; m_misses = 0; m_invals = 0;
        m_init_arrays();

        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_hit", rsp_hit, 0);
        chk("rst_l2v", l2_req_valid, 0);
        chk("rst_l2a", l2_req_addr, 0);
        chk("rst_dbg", dbg_entry, 0);
        chk_stats();
        rst = 1'b0;
        for (int k = 1; k <= SETS; k++) begin
            @(negedge clk);
            if (k == SETS - 1) begin
                chk("init_ready_low", req_ready, 0);
                chk("init_no_rsp", rsp_valid, 0);
            end
            if (k == SETS) chk("init_ready_rise", req_ready, 1);
        end
        dbg_read(0, 3, e);
        chk("dbg_s0w3_lit", e, 68'h0);
        dbg_read(0, 0, e);
        chk("dbg_s0w0_lit", e, 68'h3);

        do_cmd(2'd0, 32'h0000_1000, 5, 0, h);
        chk("r1_miss_lit", h, 0);
        chk("r1_l2addr_lit", last_l2_addr, 32'h0000_1000);
        do_cmd(2'd0, 32'h0000_1000, 0, 0, h);
        chk("r2_hit_lit", h, 1);
        @(negedge clk);
`ifdef ICACHE_STATS_EN
        chk("hits_lit", stat_hits, 1);
        chk("misses_lit", stat_misses, 1);
`else
        chk("hits_lit", stat_hits, 0);
        chk("misses_lit", stat_misses, 0);
`endif

        for (int t = 1; t <= 5; t++) begin
            do_cmd(2'd0, mk_addr(t, 0, 0), 2, 1, h);
            chk("evict_seq_miss_lit", h, 0);
        end
        do_cmd(2'd0, mk_addr(1, 0, 4), 1, 0, h);
        chk("evicted_rereads_miss_lit", h, 0);
        do_cmd(2'd1, mk_addr(3, 0, 0), 0, 0, h);
        chk("inval_hit_lit", h, 1);
        dbg_read(0, 2, e);
        chk("inval_entry_lit", e, {64'd3, 1'b0, 3'd3});
        do_cmd(2'd0, mk_addr(9, 0, 0), 1, 0, h);
        dbg_read(0, 2, e);
        chk("refill_entry_lit", e, {64'd9, 1'b1, 3'd0});
        for (int w = 0; w < WAYS; w++) dbg_chk(0, w);

        // Reset while a fill is outstanding.
        wait_ready();
        chk_stats();
        req_valid = 1'b1; req_cmd = 2'd0; req_addr = mk_addr(51, 5, 0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mr_l2v", l2_req_valid, 1);
        l2_req_ready = 1'b1;
        @(negedge clk);
        l2_req_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_l2v_drop", l2_req_valid, 0);
        chk("mr_ready", req_ready, 0);
        chk("mr_rsp", rsp_valid, 0);
        l2_rsp_valid = 1'b1;
        @(negedge clk);
        l2_rsp_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("mr_no_rsp", rsp_valid, 0);
            chk("mr_in_init", req_ready, 0);
            @(negedge clk);
        end
        m_reads = 0; m_hits = 0; m_misses = 0; m_invals = 0;
        m_init_arrays();
        wait_ready();
        for (int w = 0; w < WAYS; w++) dbg_chk(5, w);
        do_cmd(2'd0, mk_addr(51, 5, 0), 0, 0, h);
        chk("mr_reread_miss_lit", h, 0);

        for (int i = 0; i < 200; i++) begin
            cmd_sel = $urandom_range(0, 99);
            a = mk_addr($urandom_range(0, 9), $urandom_range(0, 3), $urandom_range(0, 63));
            if (i == 80 || i == 160)
                do_cmd(2'd2, a, 0, 0, h);
            else if (cmd_sel < 62)
                do_cmd(2'd0, a, $urandom_range(0, 6), $urandom_range(0, 3), h);
            else if (cmd_sel < 85)
                do_cmd(2'd1, a, 0, 0, h);
            else
                do_cmd(2'd3, a, 0, 0, h);
            idle($urandom_range(0, 2));
            if (i % 25 == 24)
                for (int s = 0; s < 4; s++)
                    for (int w = 0; w < WAYS; w++) dbg_chk(s, w);
        end
        wait_ready();
        chk_stats();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
